weight_bank_loader: RTL and testbench
=====================================

Name: weight_bank_loader

Overview:
Controller that sequences a bank of NUM_REGS shared-bus weight registers for the CNN datapath, for example the 9 taps of a 3x3 kernel. It accepts weight words from a valid/ready stream and issues one synchronous clear to the whole bank. It then drives the shared data bus plus a one-hot, active-low load strobe to each register in index order, and pulses Done once the last register has captured its word. It sits between the weight-fetch logic and the register bank that feeds the MAC array.

Parameters:
DATAWIDTH_BUS, 8, width of one weight word and of the shared register data bus
NUM_REGS, 9, number of registers in the bank (legal range 2..16)
INDEX_WIDTH, 4, width of the index counter; 2^INDEX_WIDTH >= NUM_REGS

Ports:
WeightLoader_CLOCK  in  1  single clock; all state updates on the rising edge
WeightLoader_Reset_InLow  in  1  asynchronous, active-low reset
WeightLoader_Start_InHigh  in  1  begins a bank load; sampled only in IDLE
WeightLoader_Abort_InHigh  in  1  cancels a load in progress
WeightLoader_DataInBUS  in  DATAWIDTH_BUS  incoming weight word
WeightLoader_DataValid_InHigh  in  1  DataInBUS holds a valid word
WeightLoader_DataReady_OutHigh  out  1  loader accepts a word this cycle
WeightLoader_RegDataOutBUS  out  DATAWIDTH_BUS  shared data bus to all bank registers
WeightLoader_RegLoad_OutLow  out  NUM_REGS  bit i is the active-low load strobe of register i
WeightLoader_RegClear_OutHigh  out  1  synchronous clear to all bank registers
WeightLoader_Index_OutBUS  out  INDEX_WIDTH  index of the next register to be written
WeightLoader_Busy_OutHigh  out  1  high in every state except IDLE
WeightLoader_Done_OutHigh  out  1  one-cycle pulse when the bank is fully loaded

Behaviour:
- States: IDLE, CLEAR, LOAD, LAST, DONE. All outputs are registered except DataReady, which is decoded directly from the state.
- Asynchronous reset (Reset_InLow=0) forces the following, holding while reset is low:
  - state IDLE, Index 0
  - RegLoad all 1s, RegClear 0, RegDataOutBUS 0
  - Done 0, Busy 0, DataReady 0
- IDLE: Start=1 and Abort=0 moves to CLEAR. Start while not IDLE is ignored.
- CLEAR: lasts exactly one cycle with RegClear=1 and Index reset to 0, then moves to LOAD.
- LOAD: DataReady=1. When Valid=1, a word is accepted at the edge.
  - That edge latches DataInBUS onto RegDataOutBUS and drives RegLoad[Index]=0 for exactly one cycle.
  - The bank register captures the word at the following edge.
  - Index then increments.
  - Valid=0 stalls: no strobe, and Index and bus hold.
  - Back-to-back accepts are allowed, one word per cycle.
- Accepting the word when Index=NUM_REGS-1 moves to LAST.
  - In LAST the final strobe is active and DataReady=0; the state lasts one cycle, then goes to DONE.
- DONE: Done=1 for one cycle, all strobes inactive, then back to IDLE.
  - Start-to-Done latency with Valid held high is NUM_REGS+3 cycles.
- RegLoad is all 1s except during the single strobe cycle of each word. At most one bit is low in any cycle.
- RegClear and any RegLoad bit are never active in the same cycle.
- Abort=1 in CLEAR, LOAD or LAST:
  - next state is IDLE and no Done pulse is issued;
  - a strobe already on the outputs completes its cycle; no new strobe is issued;
  - a word offered in the same cycle as Abort is not accepted (DataReady is forced to 0).
  - Registers already written keep their contents; the caller must restart to obtain a clean bank.
- Abort and Start together in IDLE: Abort wins and the state stays IDLE.
- Abort in DONE has no effect; Done still pulses.
- RegDataOutBUS holds its last value between words. Index never wraps past NUM_REGS-1 inside a load.
- Reset asserted mid-load returns all outputs to their reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset release, then Start with NUM_REGS=9, Valid held high, words 0x01..0x09 -> RegClear high for 1 cycle; RegLoad walks 0x1FE, 0x1FD, ... 0x0FF, one word per cycle; bank reads 0x01..0x09; Done pulses once, 12 cycles after Start.
- Same load with Valid toggling 1,0,1,0 -> strobes appear only on accepted words; Index holds during gaps; final bank contents identical; Done still single-cycle.
- Abort asserted while Index=4 -> next cycle IDLE, Busy=0, no Done; registers 0..3 (plus register 4 if its strobe already issued) keep data; new Start clears the bank first.
- Start pulsed during LOAD and Start+Abort together in IDLE -> no state change, no extra RegClear.
- Reset_InLow driven low mid-LOAD, asynchronously between edges -> RegLoad=all 1s, Busy=0, DataReady=0 immediately; after release the block sits in IDLE.
- Assertion checks throughout -> at most one RegLoad bit low per cycle; RegClear never overlaps a strobe; DataReady=1 only in LOAD.

Source files
------------

// File: rtl/weight_bank_loader.sv
// Sequences a bank of shared-bus weight registers: one bank-wide clear, then one
// active-low load strobe per accepted word in index order, then a single Done pulse.
module weight_bank_loader #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int NUM_REGS      = 9,
  parameter int INDEX_WIDTH   = 4
) (
  input  logic                     WeightLoader_CLOCK,
  input  logic                     WeightLoader_Reset_InLow,
  input  logic                     WeightLoader_Start_InHigh,
  input  logic                     WeightLoader_Abort_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] WeightLoader_DataInBUS,
  input  logic                     WeightLoader_DataValid_InHigh,
  output logic                     WeightLoader_DataReady_OutHigh,
  output logic [DATAWIDTH_BUS-1:0] WeightLoader_RegDataOutBUS,
  output logic [NUM_REGS-1:0]      WeightLoader_RegLoad_OutLow,
  output logic                     WeightLoader_RegClear_OutHigh,
  output logic [INDEX_WIDTH-1:0]   WeightLoader_Index_OutBUS,
  output logic                     WeightLoader_Busy_OutHigh,
  output logic                     WeightLoader_Done_OutHigh
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_LAST,
    S_DONE
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_REGS - 1);

  state_t                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]   index_q, index_d;
  logic [DATAWIDTH_BUS-1:0] data_q, data_d;
  logic [NUM_REGS-1:0]      load_n_q, load_n_d;
  logic                     clear_q, clear_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     accept;

  // Abort vetoes acceptance in the same cycle, so ready is the only unregistered output.
  assign WeightLoader_DataReady_OutHigh = (state_q == S_LOAD) && !WeightLoader_Abort_InHigh;
  assign accept = WeightLoader_DataReady_OutHigh && WeightLoader_DataValid_InHigh;

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    data_d   = data_q;
    load_n_d = '1;
    case (state_q)
      S_IDLE: begin
        if (WeightLoader_Start_InHigh && !WeightLoader_Abort_InHigh) begin
          state_d = S_CLEAR;
          index_d = '0;
        end
      end
      S_CLEAR: begin
        state_d = WeightLoader_Abort_InHigh ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        if (WeightLoader_Abort_InHigh) begin
          state_d = S_IDLE;
        end else if (accept) begin
          data_d = WeightLoader_DataInBUS;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (index_q == INDEX_WIDTH'(i)) load_n_d[i] = 1'b0;
          end
          // Index saturates on the final register so it never wraps inside a load.
          if (index_q == LAST_INDEX) state_d = S_LAST;
          else index_d = index_q + 1'b1;
        end
      end
      S_LAST: begin
        state_d = WeightLoader_Abort_InHigh ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    clear_d = (state_d == S_CLEAR);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge WeightLoader_CLOCK or negedge WeightLoader_Reset_InLow) begin
    if (!WeightLoader_Reset_InLow) begin
      state_q  <= S_IDLE;
      index_q  <= '0;
      data_q   <= '0;
      load_n_q <= '1;
      clear_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      data_q   <= data_d;
      load_n_q <= load_n_d;
      clear_q  <= clear_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign WeightLoader_RegDataOutBUS    = data_q;
  assign WeightLoader_RegLoad_OutLow   = load_n_q;
  assign WeightLoader_RegClear_OutHigh = clear_q;
  assign WeightLoader_Index_OutBUS     = index_q;
  assign WeightLoader_Busy_OutHigh     = busy_q;
  assign WeightLoader_Done_OutHigh     = done_q;

endmodule

// File: tb/tb_weight_bank_loader.sv
// Bench for weight_bank_loader: table of load scenarios, randomized loads against a
// word-list model of the bank, and hand-written reset/abort/start corner sequences.
module tb_weight_bank_loader;

  localparam int DW = 8;
  localparam int NR = 9;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, valid;
  logic [DW-1:0] din;
  logic          ready, rclear, busy, done;
  logic [DW-1:0] rdata;
  logic [NR-1:0] rload;
  logic [IW-1:0] idx;

  int tests = 0;
  int failures = 0;
  int strobe_cnt, done_cnt, clear_cnt;
  bit mon_en = 1'b0;

  logic [DW-1:0] bank [NR];
  logic [DW-1:0] words [NR];
  logic [DW-1:0] bus_exp;

  typedef struct {
    logic [15:0] vpat;
    int          vlen;
    int          abort_at;
    bit          start_in_load;
    int          exp_lat;
    int          exp_acc;
  } vec_t;

  vec_t vecs [8];

  weight_bank_loader #(.DATAWIDTH_BUS(DW), .NUM_REGS(NR), .INDEX_WIDTH(IW)) dut (
    .WeightLoader_CLOCK             (clk),
    .WeightLoader_Reset_InLow       (rst_n),
    .WeightLoader_Start_InHigh      (start),
    .WeightLoader_Abort_InHigh      (abort),
    .WeightLoader_DataInBUS         (din),
    .WeightLoader_DataValid_InHigh  (valid),
    .WeightLoader_DataReady_OutHigh (ready),
    .WeightLoader_RegDataOutBUS     (rdata),
    .WeightLoader_RegLoad_OutLow    (rload),
    .WeightLoader_RegClear_OutHigh  (rclear),
    .WeightLoader_Index_OutBUS      (idx),
    .WeightLoader_Busy_OutHigh      (busy),
    .WeightLoader_Done_OutHigh      (done)
  );

  always #5 clk = ~clk;

  // Behavioural register bank fed by the loader's bus, strobes and clear.
  always @(posedge clk) begin
    if (rclear) begin
      for (int i = 0; i < NR; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < NR; i++) if (!rload[i]) bank[i] <= rdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bank-wide invariants sampled away from the active edge.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      checkOutput("one_strobe_max", ($countones(~rload) <= 1), 1);
      checkOutput("clear_vs_strobe", (rclear && (rload != '1)), 0);
      checkOutput("ready_only_in_load", (ready && (!busy || rclear || done)), 0);
      strobe_cnt += $countones(~rload);
      done_cnt   += int'(done);
      clear_cnt  += int'(rclear);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] vpat, input int vlen,
                               input bit use_rand, input int abort_at, input bit start_in_load,
                               input int exp_lat, input int exp_acc);
    int k, accepted, last_acc, edges, acc_ref, lat_ref;
    bit aborted, v, any_set;
    logic [NR-1:0] exp_load;
    k = 0; accepted = 0; last_acc = -1; aborted = 0;
    strobe_cnt = 0; done_cnt = 0; clear_cnt = 0;
    start = 1; abort = 0; valid = 0;
    tick();
    start = 0;
    edges = 1;
    checkOutput({tag, ":clear"}, rclear, 1);
    checkOutput({tag, ":busy"}, busy, 1);
    tick();
    edges = 2;
    any_set = 0;
    for (int i = 0; i < NR; i++) any_set |= (bank[i] != '0);
    checkOutput({tag, ":bank_cleared"}, any_set, 0);
    checkOutput({tag, ":idx_start"}, idx, 0);
    while (accepted < NR && !aborted && k < 64) begin
      v = use_rand ? ($urandom_range(0, 3) != 0) : vpat[k % vlen];
      valid = v;
      din = v ? words[accepted] : DW'($urandom);
      abort = (k == abort_at);
      start = start_in_load;
      #1;
      checkOutput({tag, ":ready"}, ready, !abort);
      tick();
      start = 0;
      edges++;
      exp_load = '1;
      if (abort) begin
        aborted = 1;
        abort = 0;
        valid = 0;
      end else if (v) begin
        exp_load[accepted] = 1'b0;
        bus_exp = words[accepted];
        accepted++;
        last_acc = k;
      end
      checkOutput({tag, ":strobe"}, rload, exp_load);
      checkOutput({tag, ":bus"}, rdata, bus_exp);
      checkOutput({tag, ":idx"}, idx, (accepted < NR) ? accepted : NR - 1);
      checkOutput({tag, ":busy_load"}, busy, !aborted);
      k++;
    end
    valid = 0;
    if (abort_at == -2 && !aborted) begin
      abort = 1;
      tick();
      abort = 0;
      aborted = 1;
      checkOutput({tag, ":last_abort_busy"}, busy, 0);
      checkOutput({tag, ":last_abort_done"}, done, 0);
    end
    acc_ref = use_rand ? accepted : exp_acc;
    lat_ref = use_rand ? last_acc + 4 : exp_lat;
    if (!aborted) begin
      while (done !== 1'b1 && edges < 200) begin
        tick();
        edges++;
      end
      checkOutput({tag, ":latency"}, edges, lat_ref);
      tick();
      checkOutput({tag, ":done_width"}, done, 0);
      checkOutput({tag, ":idle_busy"}, busy, 0);
    end else begin
      repeat (3) tick();
      checkOutput({tag, ":abort_idle"}, busy, 0);
    end
    checkOutput({tag, ":done_count"}, done_cnt, aborted ? 0 : 1);
    checkOutput({tag, ":strobe_count"}, strobe_cnt, acc_ref);
    checkOutput({tag, ":clear_count"}, clear_cnt, 1);
    for (int i = 0; i < NR; i++)
      checkOutput($sformatf("%s:bank%0d", tag, i), bank[i], (i < acc_ref) ? words[i] : '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ab;
    vecs[0] = '{16'h0001, 1, -1, 1'b0, 12, 9};
    vecs[1] = '{16'h0001, 2, -1, 1'b0, 20, 9};
    vecs[2] = '{16'h0003, 3, -1, 1'b0, 16, 9};
    vecs[3] = '{16'h0002, 2, -1, 1'b0, 21, 9};
    vecs[4] = '{16'h0001, 1,  4, 1'b0,  0, 4};
    vecs[5] = '{16'h0001, 1, -1, 1'b1, 12, 9};
    vecs[6] = '{16'h0001, 1, -2, 1'b0,  0, 9};
    vecs[7] = '{16'h0001, 1,  0, 1'b0,  0, 0};

    rst_n = 0; start = 0; abort = 0; valid = 0; din = '0;
    #12;
    checkOutput("rst_load", rload, {NR{1'b1}});
    checkOutput("rst_clear", rclear, 0);
    checkOutput("rst_bus", rdata, 0);
    checkOutput("rst_idx", idx, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ready", ready, 0);
    @(negedge clk);
    rst_n = 1;
    bus_exp = '0;
    mon_en = 1;
    tick();

    start = 1; abort = 1;
    tick();
    checkOutput("start_abort_busy", busy, 0);
    checkOutput("start_abort_clear", rclear, 0);
    start = 0; abort = 0;
    tick();
    checkOutput("start_abort_stay", busy, 0);

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < NR; j++) words[j] = (i == 0) ? DW'(j + 1) : DW'($urandom);
      applyStimulus($sformatf("vec%0d", i), vecs[i].vpat, vecs[i].vlen, 1'b0, vecs[i].abort_at,
                    vecs[i].start_in_load, vecs[i].exp_lat, vecs[i].exp_acc);
    end

    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < NR; j++) words[j] = DW'($urandom);
      case ($urandom_range(0, 3))
        0: ab = $urandom_range(0, 14);
        1: ab = -2;
        default: ab = -1;
      endcase
      applyStimulus($sformatf("rnd%0d", i), 16'h0, 1, 1'b1, ab, 1'(($urandom_range(0, 1))), 0, 0);
    end

    start = 1;
    tick();
    start = 0;
    tick();
    valid = 1; din = 8'hA5;
    tick();
    din = 8'h5A;
    tick();
    #3;
    rst_n = 0;
    #1;
    checkOutput("midrst_load", rload, {NR{1'b1}});
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", ready, 0);
    checkOutput("midrst_idx", idx, 0);
    checkOutput("midrst_bus", rdata, 0);
    valid = 0;
    @(negedge clk);
    rst_n = 1;
    tick();
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_clear", rclear, 0);
    checkOutput("post_rst_idx", idx, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
